// File: rtl/leading_zeros_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : leading_zeros_decoder_if
// Description : Input/output valid-ready bundle for the leading-zero reducer.
// Revision    : 1.0 - initial release
// ============================================================================
interface leading_zeros_decoder_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] in_enc;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_W-1:0]      lz_count;
    logic                  all_zero;
    logic [DATA_WIDTH-1:0] norm_data;

    modport master (
        output in_valid, in_data, in_enc, out_ready,
        input  in_ready, out_valid, lz_count, all_zero, norm_data
    );

    modport slave (
        input  in_valid, in_data, in_enc, out_ready,
        output in_ready, out_valid, lz_count, all_zero, norm_data
    );
endinterface
`default_nettype wire

// File: rtl/leading_zeros_decoder.sv
`default_nettype none
// ============================================================================
// Module      : leading_zeros_decoder
// Description : Pipelined merge tree reducing pair leading-zero codes to one
//               count; LZD_NORMALIZE_EN adds a registered normalizing shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module leading_zeros_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    leading_zeros_decoder_if.slave   bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam int LVL   = $clog2(DATA_WIDTH) - 1;
    localparam int NP    = DATA_WIDTH / 2;

    logic                  w_adv;
    logic                  w_out_vld;
    logic                  w_fin_vld;
    logic [CNT_W-1:0]      w_fin_grp;
    logic [NP-1:0][1:0]    w_l0;

    // Global stall: every stage moves together, only when the output can drain.
    assign w_adv        = !w_out_vld || bus.out_ready;
    assign bus.in_ready = w_adv;

    // Illegal pair code 2'b11 is folded onto 2'b00 (top bit set).
    for (genvar p = 0; p < NP; p++) begin : g_pair
        assign w_l0[p] = (bus.in_enc[2*p+1 -: 2] == 2'b11) ? 2'b00 : bus.in_enc[2*p+1 -: 2];
    end

    for (genvar j = 1; j <= LVL; j++) begin : g_lvl
        localparam int W = j + 2;
        localparam int G = DATA_WIDTH >> (j + 1);

        logic [2*G-1:0][W-2:0] w_prev;
        logic [G-1:0][W-1:0]   w_nxt;
        logic                  w_prev_vld;
        logic [G-1:0][W-1:0]   r_grp;
        logic                  r_vld;

        if (j == 1) begin : g_src
            assign w_prev     = w_l0;
            assign w_prev_vld = bus.in_valid;
        end else begin : g_src
            assign w_prev     = g_lvl[j-1].r_grp;
            assign w_prev_vld = g_lvl[j-1].r_vld;
        end

        for (genvar g = 0; g < G; g++) begin : g_mrg
            logic [W-2:0] w_hi;
            logic [W-2:0] w_lo;
            assign w_hi = w_prev[2*g+1];
            assign w_lo = w_prev[2*g];
            assign w_nxt[g] = !w_hi[W-2] ? {2'b00, w_hi[W-3:0]} :
                              !w_lo[W-2] ? {2'b01, w_lo[W-3:0]} :
                                           {1'b1, {(W-1){1'b0}}};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_grp <= '0;
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_grp <= w_nxt;
                r_vld <= w_prev_vld;
            end
        end

`ifdef LZD_NORMALIZE_EN
        logic [DATA_WIDTH-1:0] w_prev_data;
        logic [DATA_WIDTH-1:0] r_data;

        if (j == 1) begin : g_dsrc
            assign w_prev_data = bus.in_data;
        end else begin : g_dsrc
            assign w_prev_data = g_lvl[j-1].r_data;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
            end else if (w_adv) begin
                r_data <= w_prev_data;
            end
        end
`endif
    end

    assign w_fin_vld = g_lvl[LVL].r_vld;
    assign w_fin_grp = g_lvl[LVL].r_grp[0];

`ifdef LZD_NORMALIZE_EN
    logic                  r_out_vld;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_az;
    logic [DATA_WIDTH-1:0] r_norm;

    // {Z, C} of the final group is the count itself, so Z=1 reads as DATA_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_cnt     <= '0;
            r_az      <= 1'b0;
            r_norm    <= '0;
        end else if (w_adv) begin
            r_out_vld <= w_fin_vld;
            r_cnt     <= w_fin_grp;
            r_az      <= w_fin_grp[CNT_W-1];
            r_norm    <= w_fin_grp[CNT_W-1] ? '0 : (g_lvl[LVL].r_data << w_fin_grp);
        end
    end

    assign w_out_vld     = r_out_vld;
    assign bus.out_valid = r_out_vld;
    assign bus.lz_count  = r_cnt;
    assign bus.all_zero  = r_az;
    assign bus.norm_data = r_norm;
`else
    assign w_out_vld     = w_fin_vld;
    assign bus.out_valid = w_fin_vld;
    assign bus.lz_count  = w_fin_grp;
    assign bus.all_zero  = w_fin_grp[CNT_W-1];
    assign bus.norm_data = '0;
`endif

endmodule
`default_nettype wire
